// File: rtl/dbg_uart_pkg.sv
// Shared definitions for the debug UART: FSM state, frame geometry and the
// default bit period, also used by the command receiver.
package dbg_uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int FRAME_BITS       = 10;
  localparam int DEFAULT_BAUD_DIV = 434;

  // 8N1 frame as shifted out LSB first: start(0), data[0..7], stop(1).
  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; push and pop may coincide and
// push is judged against the pre-pop full flag.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign dout  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wr_en  = push & ~full;
    rd_en  = pop & ~empty;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    if (rd_en) rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dbg_uart_tx.sv
// Debug UART transmitter: queues bytes in a small FIFO and sends them as
// back-to-back 8N1 frames at a fixed bit period.
module dbg_uart_tx
  import dbg_uart_pkg::*;
#(
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       fifo_full,
  output logic       ovfl,
  output logic       tx_done,
  output logic       busy,
  output logic       TX
);

  localparam int BW = $clog2(BAUD_DIV);

  state_e                state_q, state_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [3:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  ovfl_q, ovfl_d;

  logic       push;
  logic       pop;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       bit_end;
  logic       last_bit;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (tx_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    push     = trmt & ~fifo_full;
    bit_end  = (state_q == SEND) && (baud_q == BW'(BAUD_DIV - 1));
    last_bit = bit_end && (bit_q == 4'(FRAME_BITS - 1));
    pop      = ~fifo_empty & ((state_q == IDLE) | last_bit);

    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;

    if (state_q == IDLE) begin
      if (pop) begin
        shift_d = frame_of(fifo_dout);
        baud_d  = '0;
        bit_d   = '0;
        state_d = SEND;
      end
    end else if (bit_end) begin
      baud_d  = '0;
      shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
      bit_d   = bit_q + 4'd1;
      // Reloading here makes the next start bit follow the stop bit directly.
      if (last_bit) begin
        if (pop) begin
          shift_d = frame_of(fifo_dout);
          bit_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
    end else begin
      baud_d = baud_q + BW'(1);
    end

    tx_d   = (state_d == SEND) ? shift_d[0] : 1'b1;
    // Registered one cycle early so the pulse lands on the last stop-bit clock.
    done_d = (state_q == SEND) && (bit_q == 4'(FRAME_BITS - 1)) &&
             (baud_q == BW'(BAUD_DIV - 2));
    ovfl_d = ovfl_q | (trmt & fifo_full);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      ovfl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      ovfl_q  <= ovfl_d;
    end
    shift_q <= shift_d;
  end

  assign TX      = tx_q;
  assign tx_done = done_q;
  assign ovfl    = ovfl_q;
  assign busy    = (state_q == SEND) | ~fifo_empty;

endmodule

// File: tb/tb_dbg_uart_tx.sv
// Directed bench for dbg_uart_tx with a 16-cycle bit period and 4-deep FIFO.
module tb_dbg_uart_tx;

  localparam int BD = 16;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       trmt;
  logic [7:0] tx_data;
  logic       fifo_full;
  logic       ovfl;
  logic       tx_done;
  logic       busy;
  logic       TX;

  int n_assert = 0;
  int n_fail   = 0;

  dbg_uart_tx #(
    .BAUD_DIV   (BD),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .trmt      (trmt),
    .tx_data   (tx_data),
    .fifo_full (fifo_full),
    .ovfl      (ovfl),
    .tx_done   (tx_done),
    .busy      (busy),
    .TX        (TX)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    trmt = 1'b0;
    tick();
    tick();
    rst  = 1'b0;
  endtask

  // Walks one frame from cycle offset c0 (0 = first start-bit cycle), checking
  // both ends of every bit and that tx_done pulses only on the final cycle.
  // Optionally pushes push_b during frame cycle push_c.
  task automatic rx_frame(input logic [7:0] b, input string tag, input int c0,
                          input int push_c, input logic [7:0] push_b);
    logic [9:0] f;
    int dones;
    f     = {1'b1, b, 1'b0};
    dones = 0;
    for (int c = c0; c < 10 * BD; c++) begin
      trmt    = (c == push_c);
      tx_data = push_b;
      if ((c % BD == 0) || (c % BD == BD - 1)) chk({tag, "_tx"}, TX, f[c / BD]);
      if (tx_done) begin
        dones++;
        chk({tag, "_done_at"}, c, 10 * BD - 1);
      end
      tick();
    end
    trmt = 1'b0;
    chk({tag, "_ndone"}, dones, 1);
  endtask

  initial begin
    int bad_tx;
    int bad_busy;
    int dones;

    rst     = 1'b1;
    trmt    = 1'b0;
    tx_data = 8'h00;
    tick(); tick(); tick();
    chk("rst_tx", TX, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_ovfl", ovfl, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Single byte, latency and bit order
    trmt = 1'b1; tx_data = 8'hA5;
    tick();
    trmt = 1'b0;
    chk("t1_lat_tx", TX, 1);
    chk("t1_lat_busy", busy, 1);
    tick();
    rx_frame(8'hA5, "t1", 0, -1, 8'h00);
    chk("t1_idle_tx", TX, 1);
    chk("t1_idle_busy", busy, 0);
    tick(); tick();

    // Three back-to-back frames
    trmt = 1'b1; tx_data = 8'h01;
    tick();
    tx_data = 8'h02;
    tick();
    rx_frame(8'h01, "t2_f0", 0, 0, 8'h03);
    rx_frame(8'h02, "t2_f1", 0, -1, 8'h00);
    rx_frame(8'h03, "t2_f2", 0, -1, 8'h00);
    chk("t2_idle_tx", TX, 1);
    chk("t2_idle_busy", busy, 0);

    // Six pushes into a 4-deep FIFO: one dropped
    do_reset();
    chk("t3_ovfl0", ovfl, 0);
    trmt = 1'b1; tx_data = 8'h10;
    tick();
    tx_data = 8'h11;
    tick();
    chk("t3_start", TX, 0);
    tx_data = 8'h12;
    tick();
    tx_data = 8'h13;
    tick();
    tx_data = 8'h14;
    tick();
    chk("t3_full", fifo_full, 1);
    chk("t3_ovfl_pre", ovfl, 0);
    tx_data = 8'h15;
    tick();
    trmt = 1'b0;
    chk("t3_ovfl", ovfl, 1);
    chk("t3_full_hold", fifo_full, 1);
    rx_frame(8'h10, "t3_f0", 4, -1, 8'h00);
    rx_frame(8'h11, "t3_f1", 0, -1, 8'h00);
    rx_frame(8'h12, "t3_f2", 0, -1, 8'h00);
    rx_frame(8'h13, "t3_f3", 0, -1, 8'h00);
    rx_frame(8'h14, "t3_f4", 0, -1, 8'h00);
    chk("t3_idle_tx", TX, 1);
    chk("t3_idle_busy", busy, 0);
    chk("t3_ovfl_sticky", ovfl, 1);
    tick();
    chk("t3_no6th", TX, 1);

    // Push while full, coinciding with the end-of-frame pop
    do_reset();
    trmt = 1'b1; tx_data = 8'h20;
    tick();
    tx_data = 8'h21;
    tick();
    tx_data = 8'h22;
    tick();
    tx_data = 8'h23;
    tick();
    tx_data = 8'h24;
    tick();
    trmt = 1'b0;
    chk("t4_full", fifo_full, 1);
    chk("t4_ovfl0", ovfl, 0);
    rx_frame(8'h20, "t4_f0", 3, 10 * BD - 1, 8'hEE);
    chk("t4_ovfl", ovfl, 1);
    chk("t4_notfull", fifo_full, 0);
    rx_frame(8'h21, "t4_f1", 0, -1, 8'h00);
    rx_frame(8'h22, "t4_f2", 0, -1, 8'h00);
    rx_frame(8'h23, "t4_f3", 0, -1, 8'h00);
    rx_frame(8'h24, "t4_f4", 0, -1, 8'h00);
    chk("t4_idle_tx", TX, 1);
    chk("t4_idle_busy", busy, 0);

    // Reset during data bit 4 of 0x3C
    do_reset();
    trmt = 1'b1; tx_data = 8'h3C;
    tick();
    trmt = 1'b0;
    tick();
    dones = 0;
    for (int c = 0; c < 88; c++) begin
      if (c == 16) chk("t5_bit0", TX, 0);
      if (c == 48) chk("t5_bit2", TX, 1);
      if (tx_done) dones++;
      tick();
    end
    chk("t5_busy_pre", busy, 1);
    chk("t5_done_pre", dones, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_tx", TX, 1);
    chk("t5_busy", busy, 0);
    chk("t5_ovfl", ovfl, 0);
    chk("t5_done", tx_done, 0);
    bad_tx = 0; dones = 0;
    for (int c = 0; c < 200; c++) begin
      if (TX !== 1'b1) bad_tx++;
      if (tx_done) dones++;
      tick();
    end
    chk("t5_quiet_tx", bad_tx, 0);
    chk("t5_quiet_done", dones, 0);
    trmt = 1'b1; tx_data = 8'h55;
    tick();
    trmt = 1'b0;
    tick();
    rx_frame(8'h55, "t5_f", 0, -1, 8'h00);
    chk("t5_idle_busy", busy, 0);

    // Long idle after reset
    do_reset();
    bad_tx = 0; bad_busy = 0; dones = 0;
    for (int c = 0; c < 1000; c++) begin
      if (TX !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
      if (tx_done) dones++;
      tick();
    end
    chk("t6_tx", bad_tx, 0);
    chk("t6_busy", bad_busy, 0);
    chk("t6_done", dones, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
